// File: rtl/cad_pkg.sv
// Shared constants and state encoding for the CAD result output path.
package cad_pkg;

  localparam int DATA_W     = 20;
  localparam int LEN_W      = 11;
  localparam int FIFO_DEPTH = 4;

  // Words per frame produced upstream, by mode and matrix size
  localparam int LEN_CONV_8    = 4;
  localparam int LEN_CONV_16   = 36;
  localparam int LEN_CONV_32   = 196;
  localparam int LEN_DECONV_8  = 144;
  localparam int LEN_DECONV_16 = 400;
  localparam int LEN_DECONV_32 = 1296;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARM   = 2'd1,
    S_SHIFT = 2'd2
  } state_e;

endpackage

// File: rtl/cad_res_fifo.sv
// Small result buffer between the compute engine and the serializer.
// The head word is visible combinationally so a pop can load it in the same cycle.
module cad_res_fifo
#(
  parameter int W     = cad_pkg::DATA_W,
  parameter int DEPTH = cad_pkg::FIFO_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic         do_push, do_pop;

  // Pointers carry one extra wrap bit to tell full from empty
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/cad_out_serializer.sv
// Buffers 20-bit results and streams each frame LSB first on out_valid/out_value,
// with no gaps between words; missing words are replaced by zeros and flagged.
module cad_out_serializer
#(
  parameter int DATA_W     = cad_pkg::DATA_W,
  parameter int FIFO_DEPTH = cad_pkg::FIFO_DEPTH,
  parameter int LEN_W      = cad_pkg::LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic [LEN_W-1:0]  frame_len,
  input  logic              res_valid,
  input  logic [DATA_W-1:0] res_data,
  output logic              res_ready,
  output logic              out_valid,
  output logic              out_value,
  output logic              busy,
  output logic              frame_done,
  output logic              err_underrun
);

  import cad_pkg::*;

  localparam int                BIT_W    = $clog2(DATA_W);
  localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(DATA_W - 1);
  localparam logic [LEN_W-1:0]  ONE_WORD = LEN_W'(1);

  state_e              state_q;
  logic [DATA_W-1:0]   shreg_q;
  logic [BIT_W-1:0]    bit_cnt_q;
  logic [LEN_W-1:0]    words_left_q;
  logic                busy_q, done_pend_q, frame_done_q;
  logic                out_valid_q, out_value_q, err_q;

  logic                fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [DATA_W-1:0]   fifo_rdata;
  logic                word_boundary, more_words;

  assign word_boundary = (state_q == S_SHIFT) && (bit_cnt_q == LAST_BIT);
  assign more_words    = (words_left_q > ONE_WORD);
  assign fifo_pop      = !fifo_empty &&
                         ((state_q == S_ARM) || (word_boundary && more_words));
  assign res_ready     = !fifo_full && !rst;
  assign fifo_push     = res_valid && res_ready;

  cad_res_fifo #(
    .W     (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .wdata_i (res_data),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      words_left_q <= '0;
      busy_q       <= 1'b0;
      done_pend_q  <= 1'b0;
      frame_done_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_value_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          out_valid_q <= 1'b0;
          out_value_q <= 1'b0;
          // The cycle after the last bit closes the frame; busy still masks frame_start here
          if (done_pend_q) begin
            done_pend_q  <= 1'b0;
            frame_done_q <= 1'b1;
            busy_q       <= 1'b0;
          end else if (frame_start && !busy_q) begin
            words_left_q <= frame_len;
            if (frame_len == '0) begin
              frame_done_q <= 1'b1;
            end else begin
              busy_q  <= 1'b1;
              state_q <= S_ARM;
            end
          end
        end
        S_ARM: begin
          if (!fifo_empty) begin
            shreg_q   <= fifo_rdata;
            bit_cnt_q <= '0;
            state_q   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          out_valid_q <= 1'b1;
          out_value_q <= shreg_q[0];
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_q <= '0;
            if (more_words) begin
              words_left_q <= words_left_q - ONE_WORD;
              // An empty FIFO still consumes the slot so frame length is preserved
              if (!fifo_empty) begin
                shreg_q <= fifo_rdata;
              end else begin
                shreg_q <= '0;
                err_q   <= 1'b1;
              end
            end else begin
              done_pend_q <= 1'b1;
              state_q     <= S_IDLE;
            end
          end else begin
            shreg_q   <= shreg_q >> 1;
            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign out_valid    = out_valid_q;
  assign out_value    = out_value_q;
  assign busy         = busy_q;
  assign frame_done   = frame_done_q;
  assign err_underrun = err_q;

endmodule

// File: tb/tb_cad_out_serializer.sv
// Scenario bench for cad_out_serializer: words go in through a queue model and the
// captured serial stream is reassembled into words and compared against it.
module tb_cad_out_serializer;

  localparam int DW = 20;
  localparam int LW = 11;
  localparam int PUSH_BOUND = 400;

  logic          clk = 1'b0;
  logic          rst;
  logic          frame_start;
  logic [LW-1:0] frame_len;
  logic          res_valid;
  logic [DW-1:0] res_data;
  logic          res_ready, out_valid, out_value, busy, frame_done, err_underrun;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] model_q[$];
  logic          cap_bits[$];
  logic          cap_err[$];
  int            cap_lat, cap_timeout, cap_done_during;
  logic          cap_done_after, cap_value_after, cap_busy_after;

  cad_out_serializer dut (
    .clk          (clk),
    .rst          (rst),
    .frame_start  (frame_start),
    .frame_len    (frame_len),
    .res_valid    (res_valid),
    .res_data     (res_data),
    .res_ready    (res_ready),
    .out_valid    (out_valid),
    .out_value    (out_value),
    .busy         (busy),
    .frame_done   (frame_done),
    .err_underrun (err_underrun)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    int k;
    k = 0;
    res_valid = 1'b1;
    res_data  = w;
    while (!res_ready && k < PUSH_BOUND) begin
      tick();
      k++;
    end
    if (k >= PUSH_BOUND) begin
      total++; bad++;
      $display("FAIL push_timeout: res_ready=%0b after %0d cycles, required 1", res_ready, k);
    end else begin
      tick();
      model_q.push_back(w);
    end
    res_valid = 1'b0;
  endtask

  task automatic start_frame(input int len);
    frame_len   = LW'(len);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic capture(input int max_cycles);
    int n;
    n = 0;
    cap_bits.delete();
    cap_err.delete();
    cap_timeout = 0;
    cap_done_during = 0;
    while (!out_valid && n < max_cycles) begin
      tick();
      n++;
    end
    cap_lat = n;
    while (out_valid && n < max_cycles) begin
      cap_bits.push_back(out_value);
      cap_err.push_back(err_underrun);
      if (frame_done) cap_done_during++;
      tick();
      n++;
    end
    if (n >= max_cycles) cap_timeout = 1;
    cap_done_after  = frame_done;
    cap_value_after = out_value;
    cap_busy_after  = busy;
  endtask

  function automatic logic [DW-1:0] cap_word(input int idx);
    logic [DW-1:0] w;
    w = '0;
    for (int b = 0; b < DW; b++) begin
      if (idx * DW + b < cap_bits.size()) w[b] = cap_bits[idx * DW + b];
      else w[b] = 1'bx;
    end
    return w;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (10) tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %0b want 0", out_valid); end
    total++; if (out_value !== 1'b0) begin bad++; $display("FAIL rst_out_value: got %0b want 0", out_value); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %0b want 0", busy); end
    total++; if (err_underrun !== 1'b0) begin bad++; $display("FAIL rst_err: got %0b want 0", err_underrun); end
    total++; if (res_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %0b want 0 during reset", res_ready); end
    rst = 1'b0;
    tick();
    total++; if (res_ready !== 1'b1) begin bad++; $display("FAIL rst_ready_after: got %0b want 1", res_ready); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL rst_done: got %0b want 0", frame_done); end
  endtask

  task automatic test_basic();
    logic [DW-1:0] vals [4];
    logic [DW-1:0] exp_w [4];
    vals[0] = 20'h00001; vals[1] = 20'hFFFFF; vals[2] = 20'h80000; vals[3] = 20'h12345;
    for (int i = 0; i < 4; i++) push_word(vals[i]);
    start_frame(4);
    capture(200);
    for (int i = 0; i < 4; i++) exp_w[i] = model_q.pop_front();
    total++; if (cap_timeout != 0) begin bad++; $display("FAIL basic_timeout: frame did not end"); end
    total++; if (cap_lat != 2) begin bad++; $display("FAIL basic_latency: got %0d want 2", cap_lat); end
    total++; if (cap_bits.size() != 80) begin bad++; $display("FAIL basic_len: got %0d valid cycles want 80", cap_bits.size()); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (cap_word(i) !== exp_w[i]) begin bad++; $display("FAIL basic_word%0d: got %05h want %05h", i, cap_word(i), exp_w[i]); end
      $display("basic word %0d: %05h", i, cap_word(i));
    end
    total++; if (cap_done_during != 0) begin bad++; $display("FAIL basic_done_early: %0d pulses during frame want 0", cap_done_during); end
    total++; if (cap_done_after !== 1'b1) begin bad++; $display("FAIL basic_done: got %0b want 1 after last bit", cap_done_after); end
    total++; if (cap_value_after !== 1'b0) begin bad++; $display("FAIL basic_value_idle: got %0b want 0", cap_value_after); end
    total++; if (cap_busy_after !== 1'b0) begin bad++; $display("FAIL basic_busy: got %0b want 0", cap_busy_after); end
    total++; if (err_underrun !== 1'b0) begin bad++; $display("FAIL basic_err: got %0b want 0", err_underrun); end
    tick();
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL basic_done_width: got %0b want 0", frame_done); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] w [6];
    logic [DW-1:0] exp_w [6];
    for (int i = 0; i < 6; i++) w[i] = DW'($urandom);
    for (int i = 0; i < 4; i++) push_word(w[i]);
    total++; if (res_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_full: got %0b want 0", res_ready); end
    fork
      begin
        push_word(w[4]);
        push_word(w[5]);
      end
      begin
        start_frame(6);
        capture(400);
      end
    join
    for (int i = 0; i < 6; i++) exp_w[i] = model_q.pop_front();
    total++; if (cap_bits.size() != 120) begin bad++; $display("FAIL bp_len: got %0d contiguous valid cycles want 120", cap_bits.size()); end
    for (int i = 0; i < 6; i++) begin
      total++;
      if (cap_word(i) !== exp_w[i]) begin bad++; $display("FAIL bp_word%0d: got %05h want %05h", i, cap_word(i), exp_w[i]); end
      $display("backpressure word %0d: %05h", i, cap_word(i));
    end
    total++; if (cap_done_after !== 1'b1) begin bad++; $display("FAIL bp_done: got %0b want 1", cap_done_after); end
    total++; if (err_underrun !== 1'b0) begin bad++; $display("FAIL bp_err: got %0b want 0", err_underrun); end
  endtask

  task automatic test_zero_len();
    int seen;
    seen = 0;
    start_frame(0);
    total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL zero_done: got %0b want 1", frame_done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL zero_busy: got %0b want 0", busy); end
    tick();
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL zero_done_width: got %0b want 0", frame_done); end
    for (int i = 0; i < 10; i++) begin
      if (out_valid) seen++;
      tick();
    end
    total++; if (seen != 0) begin bad++; $display("FAIL zero_valid: %0d valid cycles want 0", seen); end
    $display("zero-length frame: valid cycles %0d", seen);
  endtask

  task automatic test_restart_ignored();
    logic [DW-1:0] exp_w [3];
    int seen;
    seen = 0;
    for (int i = 0; i < 3; i++) push_word(DW'($urandom));
    start_frame(3);
    fork
      capture(400);
      begin
        repeat (15) tick();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL restart_busy_mid: got %0b want 1", busy); end
        frame_len   = LW'(5);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
      end
    join
    for (int i = 0; i < 3; i++) exp_w[i] = model_q.pop_front();
    total++; if (cap_bits.size() != 60) begin bad++; $display("FAIL restart_len: got %0d want 60", cap_bits.size()); end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (cap_word(i) !== exp_w[i]) begin bad++; $display("FAIL restart_word%0d: got %05h want %05h", i, cap_word(i), exp_w[i]); end
      $display("restart word %0d: %05h", i, cap_word(i));
    end
    total++; if (cap_done_after !== 1'b1) begin bad++; $display("FAIL restart_done: got %0b want 1", cap_done_after); end
    for (int i = 0; i < 10; i++) begin
      if (out_valid || busy) seen++;
      tick();
    end
    total++; if (seen != 0) begin bad++; $display("FAIL restart_rearmed: %0d busy/valid cycles want 0", seen); end
  endtask

  task automatic test_underrun();
    logic [DW-1:0] exp_w [3];
    push_word(20'h0000F);
    start_frame(3);
    capture(400);
    exp_w[0] = model_q.pop_front();
    exp_w[1] = '0;
    exp_w[2] = '0;
    total++; if (cap_bits.size() != 60) begin bad++; $display("FAIL under_len: got %0d want 60", cap_bits.size()); end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (cap_word(i) !== exp_w[i]) begin bad++; $display("FAIL under_word%0d: got %05h want %05h", i, cap_word(i), exp_w[i]); end
      $display("underrun word %0d: %05h", i, cap_word(i));
    end
    if (cap_err.size() > 19) begin
      total++; if (cap_err[18] !== 1'b0) begin bad++; $display("FAIL under_err_early: got %0b want 0 before boundary", cap_err[18]); end
      total++; if (cap_err[19] !== 1'b1) begin bad++; $display("FAIL under_err_boundary: got %0b want 1", cap_err[19]); end
    end else begin
      total++; bad++;
      $display("FAIL under_err_trace: only %0d cycles captured want 60", cap_err.size());
    end
    total++; if (cap_done_after !== 1'b1) begin bad++; $display("FAIL under_done: got %0b want 1", cap_done_after); end
    repeat (5) tick();
    total++; if (err_underrun !== 1'b1) begin bad++; $display("FAIL under_sticky: got %0b want 1", err_underrun); end
  endtask

  task automatic test_async_reset();
    logic [DW-1:0] exp_w [36];
    int n, seen;
    n = 0;
    seen = 0;
    for (int i = 0; i < 4; i++) push_word(DW'($urandom));
    start_frame(196);
    while (!out_valid && n < 50) begin tick(); n++; end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL ar_start: got %0b want 1", out_valid); end
    repeat (47) tick();
    #2;
    rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ar_valid: got %0b want 0 immediately", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ar_busy: got %0b want 0", busy); end
    total++; if (res_ready !== 1'b0) begin bad++; $display("FAIL ar_ready: got %0b want 0", res_ready); end
    repeat (3) tick();
    rst = 1'b0;
    model_q.delete();
    tick();
    total++; if (err_underrun !== 1'b0) begin bad++; $display("FAIL ar_err_clear: got %0b want 0", err_underrun); end
    total++; if (res_ready !== 1'b1) begin bad++; $display("FAIL ar_ready_after: got %0b want 1", res_ready); end
    start_frame(36);
    for (int i = 0; i < 5; i++) begin
      if (out_valid) seen++;
      tick();
    end
    total++; if (seen != 0) begin bad++; $display("FAIL ar_fifo_empty: %0d valid cycles before any push want 0", seen); end
    fork
      for (int i = 0; i < 36; i++) push_word(DW'($urandom));
      capture(1500);
    join
    for (int i = 0; i < 36; i++) exp_w[i] = (model_q.size() > 0) ? model_q.pop_front() : 'x;
    total++; if (cap_lat != 3) begin bad++; $display("FAIL ar_latency: got %0d want 3", cap_lat); end
    total++; if (cap_bits.size() != 720) begin bad++; $display("FAIL ar_len: got %0d want 720", cap_bits.size()); end
    for (int i = 0; i < 36; i++) begin
      total++;
      if (cap_word(i) !== exp_w[i]) begin bad++; $display("FAIL ar_word%0d: got %05h want %05h", i, cap_word(i), exp_w[i]); end
    end
    $display("post-reset frame: %0d bits, first word %05h", cap_bits.size(), cap_word(0));
    total++; if (cap_done_after !== 1'b1) begin bad++; $display("FAIL ar_done: got %0b want 1", cap_done_after); end
    total++; if (err_underrun !== 1'b0) begin bad++; $display("FAIL ar_err: got %0b want 0", err_underrun); end
  endtask

  initial begin
    rst         = 1'b1;
    frame_start = 1'b0;
    frame_len   = '0;
    res_valid   = 1'b0;
    res_data    = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_len();
    test_restart_ignored();
    test_underrun();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
